// File: rtl/layer_seq_pkg.sv
// Shared state encoding and stage indices for the CNN layer sequencer.
package layer_seq_pkg;

   localparam int unsigned NUM_STAGES_DEF = 8;

   localparam int unsigned STG_CONV1    = 0;
   localparam int unsigned STG_RELU1    = 1;
   localparam int unsigned STG_MAXPOOL1 = 2;
   localparam int unsigned STG_CONV2    = 3;
   localparam int unsigned STG_RELU2    = 4;
   localparam int unsigned STG_MAXPOOL2 = 5;
   localparam int unsigned STG_FLATTEN  = 6;
   localparam int unsigned STG_DENSE    = 7;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LAUNCH = 3'd1,
      WAIT   = 3'd2,
      FINISH = 3'd3,
      ERROR  = 3'd4
   } state_t;

endpackage

// File: rtl/layer_seq_wdog.sv
// Per-stage WAIT timeout for the layer sequencer; built only with LAYER_SEQ_WDOG_EN.
module layer_seq_wdog #(
   parameter int unsigned WDOG_W     = 16,
   parameter int unsigned WDOG_LIMIT = 4096
) (
   input  logic clk,
   input  logic rst,
   input  logic launch,
   input  logic waiting,
   output logic expired_c
);

   localparam logic [WDOG_W-1:0] LAST = WDOG_W'(WDOG_LIMIT - 1);

   logic [WDOG_W-1:0] count;

   // count holds the number of WAIT cycles spent on the stage, current one included
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (launch) begin
         count <= WDOG_W'(1);
      end else if (waiting) begin
         count <= count + WDOG_W'(1);
      end else begin
         count <= '0;
      end
   end

   assign expired_c = waiting && (count == LAST);

endmodule

// File: rtl/layer_sequencer.sv
// Handshake sequencer for the CNN layer pipeline: launches each stage, waits for its done.
// Optional per-stage watchdog enabled with `define LAYER_SEQ_WDOG_EN.
module layer_sequencer
   import layer_seq_pkg::*;
#(
   parameter int unsigned NUM_STAGES = NUM_STAGES_DEF,
   parameter int unsigned FRAME_W    = 16,
   parameter int unsigned WDOG_W     = 16,
   parameter int unsigned WDOG_LIMIT = 16'd4096
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          abort,
   input  logic [NUM_STAGES-1:0]         stage_done,
   output logic [NUM_STAGES-1:0]         stage_start,
   output logic [NUM_STAGES-1:0]         stage_active,
   output logic [$clog2(NUM_STAGES)-1:0] cur_stage,
   output logic                          busy,
   output logic                          done,
   output logic                          error,
   output logic [FRAME_W-1:0]            frame_count
);

   localparam int unsigned           IW        = $clog2(NUM_STAGES);
   localparam logic [NUM_STAGES-1:0] ONE       = NUM_STAGES'(1);
   localparam logic [IW-1:0]         FIRST_IDX = IW'(STG_CONV1);
   localparam logic [IW-1:0]         LAST_IDX  = IW'(NUM_STAGES - 1);

   state_t                state;
   logic [IW-1:0]         idx;
   logic [IW-1:0]         idx_inc;
   logic [NUM_STAGES-1:0] own_mask;
   logic                  stray;
   logic                  hit;
   logic                  wdog_exp_c;

   assign idx_inc  = idx + IW'(1);
   assign own_mask = ONE << idx;
   assign stray    = |(stage_done & ~own_mask);
   assign hit      = stage_done[idx];

`ifdef LAYER_SEQ_WDOG_EN
   layer_seq_wdog #(
      .WDOG_W     (WDOG_W),
      .WDOG_LIMIT (WDOG_LIMIT)
   ) u_wdog (
      .clk       (clk),
      .rst       (rst),
      .launch    (state == LAUNCH),
      .waiting   (state == WAIT),
      .expired_c (wdog_exp_c)
   );
`else
   logic unused_wdog_cfg;
   assign unused_wdog_cfg = ^WDOG_W'(WDOG_LIMIT);
   assign wdog_exp_c      = 1'b0;
`endif

   // Outputs are set on the transition into each state so they read straight from flops
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         idx          <= FIRST_IDX;
         frame_count  <= '0;
         stage_start  <= '0;
         stage_active <= '0;
         cur_stage    <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
      end else begin
         stage_start <= '0;
         done        <= 1'b0;
         if (abort) begin
            state        <= IDLE;
            idx          <= FIRST_IDX;
            stage_active <= '0;
            cur_stage    <= '0;
            busy         <= 1'b0;
            error        <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     state        <= LAUNCH;
                     idx          <= FIRST_IDX;
                     stage_start  <= ONE << FIRST_IDX;
                     stage_active <= ONE << FIRST_IDX;
                     cur_stage    <= FIRST_IDX;
                     busy         <= 1'b1;
                  end
               end
               LAUNCH: begin
                  state <= WAIT;
               end
               WAIT: begin
                  if (stray || (!hit && wdog_exp_c)) begin
                     state        <= ERROR;
                     stage_active <= '0;
                     cur_stage    <= '0;
                     busy         <= 1'b0;
                     error        <= 1'b1;
                  end else if (hit && (idx == LAST_IDX)) begin
                     state        <= FINISH;
                     stage_active <= '0;
                     cur_stage    <= '0;
                     busy         <= 1'b0;
                     done         <= 1'b1;
                     frame_count  <= frame_count + FRAME_W'(1);
                  end else if (hit) begin
                     state        <= LAUNCH;
                     idx          <= idx_inc;
                     stage_start  <= ONE << idx_inc;
                     stage_active <= ONE << idx_inc;
                     cur_stage    <= idx_inc;
                  end
               end
               FINISH: begin
                  state <= IDLE;
               end
               ERROR: begin
                  state <= ERROR;
               end
               default: begin
                  state        <= IDLE;
                  idx          <= FIRST_IDX;
                  stage_active <= '0;
                  cur_stage    <= '0;
                  busy         <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: directed scenarios plus randomized traffic against a phase-level model.
module tb_layer_sequencer;
   import layer_seq_pkg::*;

   localparam int NS            = 8;
   localparam int FW            = 16;
   localparam int TB_WDOG_LIMIT = 8;
   localparam int PH_IDLE = 0, PH_RUN = 1, PH_DONE = 2, PH_ERR = 3;

   logic          clk = 1'b0;
   logic          rst, start, abort;
   logic [NS-1:0] stage_done, stage_start, stage_active;
   logic [2:0]    cur_stage;
   logic          busy, done, error;
   logic [FW-1:0] frame_count;

   always #5 clk = ~clk;

   layer_sequencer #(
      .NUM_STAGES (NS),
      .FRAME_W    (FW),
      .WDOG_W     (16),
      .WDOG_LIMIT (TB_WDOG_LIMIT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .abort        (abort),
      .stage_done   (stage_done),
      .stage_start  (stage_start),
      .stage_active (stage_active),
      .cur_stage    (cur_stage),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .frame_count  (frame_count)
   );

   int checks = 0;
   int errors = 0;
   int tnow   = 0;
   bit chk_en = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s t=%0d got=%0h want=%0h", nm, tnow, got, exp);
      end
   endtask

   // Model: phase of the frame, which stage owns the pipe, whether this is its launch cycle,
   // and how many cycles have passed since that launch.
   int       m_phase = PH_IDLE, m_stg = 0, m_age = 0, m_frames = 0;
   bit       m_launch = 0;
   int       n_phase, n_stg, n_age, n_frames;
   bit       n_launch;
   logic [NS-1:0] m_own;

   assign m_own = NS'(1) << m_stg;

   always_comb begin
      n_phase  = m_phase;
      n_stg    = m_stg;
      n_age    = m_age + 1;
      n_frames = m_frames;
      n_launch = 0;
      if (rst) begin
         n_phase = PH_IDLE; n_stg = 0; n_age = 0; n_frames = 0;
      end else if (abort) begin
         n_phase = PH_IDLE; n_stg = 0;
      end else if (m_phase == PH_IDLE) begin
         if (start) begin
            n_phase = PH_RUN; n_stg = 0; n_launch = 1; n_age = 0;
         end
      end else if (m_phase == PH_RUN && !m_launch) begin
         if ((stage_done & ~m_own) != '0) begin
            n_phase = PH_ERR;
         end else if (stage_done[m_stg]) begin
            if (m_stg == NS - 1) begin
               n_phase  = PH_DONE;
               n_frames = (m_frames + 1) % (1 << FW);
            end else begin
               n_stg = m_stg + 1; n_launch = 1; n_age = 0;
            end
         end
`ifdef LAYER_SEQ_WDOG_EN
         else if (m_age == TB_WDOG_LIMIT - 1) begin
            n_phase = PH_ERR;
         end
`endif
      end else if (m_phase == PH_DONE) begin
         n_phase = PH_IDLE;
      end
   end

   always @(posedge clk) begin
      m_phase  <= n_phase;
      m_stg    <= n_stg;
      m_age    <= n_age;
      m_frames <= n_frames;
      m_launch <= n_launch;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("stage_start",  32'(stage_start),  32'((m_phase == PH_RUN && m_launch) ? m_own : NS'(0)));
         chk("stage_active", 32'(stage_active), 32'((m_phase == PH_RUN) ? m_own : NS'(0)));
         chk("cur_stage",    32'(cur_stage),    32'((m_phase == PH_RUN) ? m_stg : 0));
         chk("busy",         32'(busy),         32'(m_phase == PH_RUN));
         chk("done",         32'(done),         32'(m_phase == PH_DONE));
         chk("error",        32'(error),        32'(m_phase == PH_ERR));
         chk("frame_count",  32'(frame_count),  32'(m_frames));
      end
   end

   // Stage responder: answers each observed launch after cnt cycles.
   bit auto_resp = 1;
   int fixed_dly = 1;
   bit pend = 0;
   int pend_idx = 0;
   int cnt = 0;
   int ev_launch_t[$], ev_launch_i[$], ev_done_t[$];

   task automatic step();
      @(posedge clk);
      #1;
      tnow++;
      stage_done = '0;
      if (!busy) pend = 0;
      if (auto_resp && pend) begin
         cnt--;
         if (cnt == 0) begin
            stage_done = NS'(1) << pend_idx;
            pend = 0;
         end
      end
      if (stage_start != '0) begin
         ev_launch_t.push_back(tnow);
         ev_launch_i.push_back(int'(cur_stage));
         if (auto_resp) begin
            pend     = 1;
            pend_idx = int'(cur_stage);
            cnt      = (fixed_dly > 0) ? fixed_dly : int'($urandom_range(1, 4));
         end
      end
      if (done) ev_done_t.push_back(tnow);
   endtask

   task automatic clear_ev();
      ev_launch_t.delete();
      ev_launch_i.delete();
      ev_done_t.delete();
   endtask

   task automatic do_reset();
      rst = 1; start = 0; abort = 0;
      step();
      step();
      rst = 0;
      auto_resp = 1;
      clear_ev();
   endtask

   task automatic wait_dones(input int n, input int budget);
      for (int i = 0; i < budget && ev_done_t.size() < n; i++) step();
      chk("done_count", 32'(ev_done_t.size()), 32'(n));
   endtask

   function automatic int q_at(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1000;
   endfunction

   initial begin
      #1000000;
      $display("FAIL global_timeout t=%0d", tnow);
      $fatal(1, "simulation did not finish");
   end

   initial begin
      rst = 1; start = 0; abort = 0; stage_done = '0;

      // Reset state
      do_reset();
      chk_en = 1;
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_active", 32'(stage_active), 32'(0));
      chk("rst_frames", 32'(frame_count), 32'(0));

      // Full frame, each done 3 cycles after its launch
      do_reset();
      fixed_dly = 3;
      start = 1; step(); start = 0;
      wait_dones(1, 60);
      chk("full_launches", 32'(ev_launch_i.size()), 32'(8));
      for (int i = 0; i < 8; i++) chk("full_order", 32'(q_at(ev_launch_i, i)), 32'(i));
      chk("full_latency", 32'(q_at(ev_done_t, 0) - q_at(ev_launch_t, 0)), 32'(32));
      chk("full_frames", 32'(frame_count), 32'(1));
      step();

      // Back-to-back frames, start held, 1-cycle dones
      do_reset();
      fixed_dly = 1;
      start = 1;
      wait_dones(2, 80);
      start = 0;
      chk("b2b_len1", 32'(q_at(ev_done_t, 0) - q_at(ev_launch_t, 0)), 32'(16));
      chk("b2b_gap", 32'(q_at(ev_launch_t, 8) - q_at(ev_done_t, 0)), 32'(2));
      chk("b2b_len2", 32'(q_at(ev_done_t, 1) - q_at(ev_launch_t, 8)), 32'(16));
      chk("b2b_frames", 32'(frame_count), 32'(2));
      chk("b2b_error", 32'(error), 32'(0));
      repeat (3) step();

      // Abort while waiting on stage 4
      do_reset();
      fixed_dly = 2;
      start = 1; step(); start = 0;
      for (int i = 0; i < 60 && !(stage_active == (NS'(1) << STG_RELU2) && stage_start == '0); i++) step();
      chk("abort_reached", 32'(stage_active), 32'(NS'(1) << STG_RELU2));
      abort = 1; step(); abort = 0;
      chk("abort_active", 32'(stage_active), 32'(0));
      chk("abort_busy", 32'(busy), 32'(0));
      clear_ev();
      repeat (6) step();
      chk("abort_nodone", 32'(ev_done_t.size()), 32'(0));
      chk("abort_frames", 32'(frame_count), 32'(0));
      start = 1; step(); start = 0;
      chk("abort_restart", 32'(q_at(ev_launch_i, 0)), 32'(STG_CONV1));
      step();

      // Stray done from stage 6 while stage 2 owns the pipe
      do_reset();
      fixed_dly = 1;
      start = 1; step(); start = 0;
      for (int i = 0; i < 30 && stage_start != (NS'(1) << STG_MAXPOOL1); i++) step();
      auto_resp = 0;
      step();
      stage_done = NS'(1) << STG_FLATTEN;
      step();
      chk("stray_error", 32'(error), 32'(1));
      chk("stray_busy", 32'(busy), 32'(0));
      start = 1;
      repeat (3) begin
         step();
         chk("stray_sticky", 32'(error), 32'(1));
         chk("stray_nostart", 32'(stage_start), 32'(0));
      end
      start = 0;
      abort = 1; step(); abort = 0;
      chk("stray_clear", 32'(error), 32'(0));
      auto_resp = 1;

      // Reset mid-frame at stage 5 with three frames counted
      do_reset();
      fixed_dly = 1;
      start = 1;
      wait_dones(3, 120);
      start = 0;
      step(); step();
      start = 1; step(); start = 0;
      for (int i = 0; i < 40 && stage_active != (NS'(1) << STG_MAXPOOL2); i++) step();
      chk("midrst_frames_before", 32'(frame_count), 32'(3));
      rst = 1; step(); rst = 0;
      chk("midrst_active", 32'(stage_active), 32'(0));
      chk("midrst_busy", 32'(busy), 32'(0));
      chk("midrst_cur", 32'(cur_stage), 32'(0));
      chk("midrst_frames", 32'(frame_count), 32'(0));

`ifdef LAYER_SEQ_WDOG_EN
      begin
         int tl;
         // Stage 1 never answers: timeout 8 cycles after its launch
         do_reset();
         fixed_dly = 1;
         start = 1; step(); start = 0;
         for (int i = 0; i < 20 && stage_start != (NS'(1) << STG_RELU1); i++) step();
         tl = tnow;
         auto_resp = 0;
         for (int i = 0; i < 20 && !error; i++) step();
         chk("wdog_latency", 32'(tnow - tl), 32'(8));
         abort = 1; step(); abort = 0;
         // Done on the last allowed cycle beats the timeout
         auto_resp = 1;
         clear_ev();
         start = 1; step(); start = 0;
         for (int i = 0; i < 20 && stage_start != (NS'(1) << STG_RELU1); i++) step();
         tl = tnow;
         pend = 1; pend_idx = STG_RELU1; cnt = 7;
         for (int i = 0; i < 12 && stage_start != (NS'(1) << STG_MAXPOOL1); i++) step();
         chk("wdog_late_done", 32'(tnow - tl), 32'(8));
         chk("wdog_no_error", 32'(error), 32'(0));
      end
`endif

      // Randomized traffic
      do_reset();
      fixed_dly = 0;
      for (int c = 0; c < 3000; c++) begin
         step();
         start = 1'($urandom_range(0, 1));
         abort = ($urandom_range(0, 63) == 0);
         rst   = ($urandom_range(0, 499) == 0);
         if ($urandom_range(0, 49) == 0) stage_done = stage_done | (NS'(1) << $urandom_range(0, NS - 1));
      end
      start = 0; abort = 0; rst = 0;
      step();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
